// File: rtl/mem_access_pkg.sv
// Shared opcodes, funct3 encodings and FSM states for the RV32I memory stage.
// The misalignment helper is only consulted when MEM_MISALIGN_TRAP_EN is defined.
package mem_access_pkg;

  localparam logic [6:0] L_OP = 7'b0000011;
  localparam logic [6:0] S_OP = 7'b0100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Halfword needs addr[0] = 0, word needs addr[1:0] = 0; bytes never trap.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3[1:0])
      2'b01:   return addr_lo[0];
      2'b10:   return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_align.sv
// Combinational byte-lane logic: store byte enables / lane replication and
// load byte/halfword extraction with sign or zero extension.
module mem_align import mem_access_pkg::*; #(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_addr_lo,
  input  logic [XLEN-1:0] i_store_data,
  input  logic [XLEN-1:0] i_load_word,
  output logic [3:0]      o_be_c,
  output logic [XLEN-1:0] o_wdata_c,
  output logic [XLEN-1:0] o_load_data_c
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;

  always_comb begin
    o_be_c    = 4'b1111;
    o_wdata_c = i_store_data;
    case (i_funct3)
      F3_SB: begin
        o_be_c    = 4'b0001 << i_addr_lo;
        o_wdata_c = XLEN'({4{i_store_data[7:0]}});
      end
      F3_SH: begin
        o_be_c    = 4'b0011 << {i_addr_lo[1], 1'b0};
        o_wdata_c = XLEN'({2{i_store_data[15:0]}});
      end
      default: ;
    endcase
  end

  // Word loads always take lane 0; halfwords only look at addr[1].
  always_comb begin
    byte_c = i_load_word[7:0];
    case (i_addr_lo)
      2'd1:    byte_c = i_load_word[15:8];
      2'd2:    byte_c = i_load_word[23:16];
      2'd3:    byte_c = i_load_word[31:24];
      default: ;
    endcase
    half_c = i_addr_lo[1] ? i_load_word[31:16] : i_load_word[15:0];

    o_load_data_c = i_load_word;
    case (i_funct3)
      F3_LB:   o_load_data_c = {{(XLEN-8){byte_c[7]}}, byte_c};
      F3_LH:   o_load_data_c = {{(XLEN-16){half_c[15]}}, half_c};
      F3_LBU:  o_load_data_c = XLEN'(byte_c);
      F3_LHU:  o_load_data_c = XLEN'(half_c);
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// RV32I memory stage: data-bus handshake FSM with timeout, forwarding and MEM/WB registers.
// Define MEM_MISALIGN_TRAP_EN to turn misaligned halfword/word accesses into bus errors.
module mem_access import mem_access_pkg::*; #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BUS_TIMEOUT = 16
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [6:0]      i_opcode,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic [4:0]      i_rd_addr,
  input  logic            i_rd_wr_en,
  input  logic [XLEN-1:0] i_alu_result,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_stall,
  output logic            o_dmem_req,
  output logic            o_dmem_we,
  output logic [XLEN-1:0] o_dmem_addr,
  output logic [XLEN-1:0] o_dmem_wdata,
  output logic [3:0]      o_dmem_be,
  input  logic            i_dmem_gnt,
  input  logic            i_dmem_rvalid,
  input  logic [XLEN-1:0] i_dmem_rdata,
  output logic            o_stall,
  output logic            o_bus_err,
  output logic [XLEN-1:0] o_rd_mem,
  output logic [4:0]      o_rd_addr_mem,
  output logic            o_rd_mem_wr_en,
  output logic [XLEN-1:0] or_rd_data,
  output logic [4:0]      or_rd_addr,
  output logic            or_rd_wr_en,
  output logic [XLEN-1:0] or_pc
);

  localparam int unsigned CNT_W = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN-1:0]   buf_q;
  logic              bus_err_q;
  logic [XLEN-1:0]   rd_data_q, rd_data_d;
  logic [4:0]        rd_addr_q, rd_addr_d;
  logic              rd_wr_en_q, rd_wr_en_d;
  logic [XLEN-1:0]   pc_q, pc_d;

  logic              is_load, is_store, is_mem, misalign_c, stall_c, timeout_hit_c, wr_ok_c;
  logic [XLEN-1:0]   load_ext_c;

  assign is_load  = (i_opcode == L_OP);
  assign is_store = (i_opcode == S_OP);
  assign is_mem   = is_load | is_store;

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign_c = is_mem & is_misaligned(i_funct3, i_alu_result[1:0]);
`else
  assign misalign_c = 1'b0;
`endif

  assign stall_c       = is_mem & (state_q != ST_DONE);
  assign timeout_hit_c = (BUS_TIMEOUT != 0) && (cnt_q == CNT_W'(BUS_TIMEOUT - 1));
  assign wr_ok_c       = i_rd_wr_en & ~is_store & ~misalign_c;

  mem_align #(.XLEN(XLEN)) u_align (
    .i_funct3      (i_funct3),
    .i_addr_lo     (i_alu_result[1:0]),
    .i_store_data  (i_rs2_data),
    .i_load_word   (buf_q),
    .o_be_c        (o_dmem_be),
    .o_wdata_c     (o_dmem_wdata),
    .o_load_data_c (load_ext_c)
  );

  // Request and stall are gated by reset so they fall immediately, even mid-access.
  assign o_dmem_req     = ~i_rst & is_mem & ~misalign_c & (state_q == ST_IDLE);
  assign o_stall        = ~i_rst & stall_c;
  assign o_dmem_we      = is_store;
  assign o_dmem_addr    = {i_alu_result[XLEN-1:2], 2'b00};
  assign o_bus_err      = bus_err_q;

  assign o_rd_mem       = is_load ? load_ext_c : i_alu_result;
  assign o_rd_addr_mem  = i_rd_addr;
  assign o_rd_mem_wr_en = i_rd_wr_en & (~is_load | (state_q == ST_DONE)) & ~misalign_c;

  assign or_rd_data  = rd_data_q;
  assign or_rd_addr  = rd_addr_q;
  assign or_rd_wr_en = rd_wr_en_q;
  assign or_pc       = pc_q;

  // MEM/WB next values: hold on downstream stall, bubble while the access is pending.
  always_comb begin
    rd_data_d  = rd_data_q;
    rd_addr_d  = rd_addr_q;
    rd_wr_en_d = rd_wr_en_q;
    pc_d       = pc_q;
    if (!i_stall) begin
      if (stall_c) begin
        rd_wr_en_d = 1'b0;
      end else begin
        rd_data_d  = is_load ? load_ext_c : i_alu_result;
        rd_addr_d  = i_rd_addr;
        rd_wr_en_d = wr_ok_c;
        pc_d       = i_pc;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      buf_q      <= '0;
      bus_err_q  <= 1'b0;
      rd_data_q  <= '0;
      rd_addr_q  <= '0;
      rd_wr_en_q <= 1'b0;
      pc_q       <= '0;
    end else begin
      bus_err_q  <= 1'b0;
      rd_data_q  <= rd_data_d;
      rd_addr_q  <= rd_addr_d;
      rd_wr_en_q <= rd_wr_en_d;
      pc_q       <= pc_d;
      case (state_q)
        ST_IDLE: begin
          if (is_mem) begin
            if (misalign_c) begin
              state_q   <= ST_DONE;
              bus_err_q <= 1'b1;
              buf_q     <= '0;
            end else if (i_dmem_gnt) begin
              state_q <= is_store ? ST_DONE : ST_WAIT;
              cnt_q   <= '0;
            end else if (timeout_hit_c) begin
              state_q   <= ST_DONE;
              bus_err_q <= 1'b1;
              buf_q     <= '0;
              cnt_q     <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        ST_WAIT: begin
          if (i_dmem_rvalid) begin
            buf_q   <= i_dmem_rdata;
            state_q <= ST_DONE;
            cnt_q   <= '0;
          end else if (timeout_hit_c) begin
            state_q   <= ST_DONE;
            bus_err_q <= 1'b1;
            buf_q     <= '0;
            cnt_q     <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (!i_stall) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: a small bus responder per step, expected MEM/WB
// results queued when an instruction is driven and compared when it retires.
module tb_mem_access;

  localparam logic [6:0] OP_LOAD  = 7'h03;
  localparam logic [6:0] OP_STORE = 7'h23;
  localparam logic [6:0] OP_ALU   = 7'h33;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [6:0]  i_opcode;
  logic [2:0]  i_funct3;
  logic [31:0] i_rs2_data;
  logic [4:0]  i_rd_addr;
  logic        i_rd_wr_en;
  logic [31:0] i_alu_result;
  logic [31:0] i_pc;
  logic        i_stall;
  logic        o_dmem_req, o_dmem_we;
  logic [31:0] o_dmem_addr, o_dmem_wdata;
  logic [3:0]  o_dmem_be;
  logic        i_dmem_gnt, i_dmem_rvalid;
  logic [31:0] i_dmem_rdata;
  logic        o_stall, o_bus_err;
  logic [31:0] o_rd_mem;
  logic [4:0]  o_rd_addr_mem;
  logic        o_rd_mem_wr_en;
  logic [31:0] or_rd_data;
  logic [4:0]  or_rd_addr;
  logic        or_rd_wr_en;
  logic [31:0] or_pc;

  always #5 i_clk = ~i_clk;

  mem_access #(.XLEN(32), .BUS_TIMEOUT(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_opcode(i_opcode), .i_funct3(i_funct3),
    .i_rs2_data(i_rs2_data), .i_rd_addr(i_rd_addr), .i_rd_wr_en(i_rd_wr_en),
    .i_alu_result(i_alu_result), .i_pc(i_pc), .i_stall(i_stall),
    .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
    .o_dmem_wdata(o_dmem_wdata), .o_dmem_be(o_dmem_be), .i_dmem_gnt(i_dmem_gnt),
    .i_dmem_rvalid(i_dmem_rvalid), .i_dmem_rdata(i_dmem_rdata), .o_stall(o_stall),
    .o_bus_err(o_bus_err), .o_rd_mem(o_rd_mem), .o_rd_addr_mem(o_rd_addr_mem),
    .o_rd_mem_wr_en(o_rd_mem_wr_en), .or_rd_data(or_rd_data), .or_rd_addr(or_rd_addr),
    .or_rd_wr_en(or_rd_wr_en), .or_pc(or_pc)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  addr;
    logic        wr;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  int          obs_stall, obs_req, obs_err, obs_unstable;
  logic        obs_err_after, obs_fwd_en, obs_fwd_en0;
  logic [3:0]  obs_be;
  logic [31:0] obs_wdata, obs_fwd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one instruction, answer the bus (gnt after gnt_dly request cycles, rvalid
  // rv_dly cycles after gnt, never if negative), then check the retired MEM/WB entry.
  task automatic run_op(input string tag, input logic [6:0] op, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] rs2, input logic [4:0] rd,
                        input logic wr, input logic [31:0] pc, input int gnt_dly,
                        input int rv_dly, input logic [31:0] rdata,
                        input logic [31:0] exp_data, input logic exp_wr);
    bit   granted = 0;
    bit   done    = 0;
    int   gcyc    = 0;
    int   idle    = 0;
    exp_t e;
    i_opcode = op; i_funct3 = f3; i_alu_result = addr; i_rs2_data = rs2;
    i_rd_addr = rd; i_rd_wr_en = wr; i_pc = pc;
    sb.push_back('{data: exp_data, addr: rd, wr: exp_wr, pc: pc});
    obs_stall = 0; obs_req = 0; obs_err = 0; obs_unstable = 0;
    obs_be = 4'h0; obs_wdata = 32'h0;
    #1;
    for (int c = 0; c < 100; c++) begin
      i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b0; i_dmem_rdata = 32'hA5A5_A5A5;
      if (granted && rv_dly >= 0 && c == gcyc + rv_dly) begin
        i_dmem_rvalid = 1'b1; i_dmem_rdata = rdata;
      end
      if (!granted && o_dmem_req) begin
        if (idle == gnt_dly) begin i_dmem_gnt = 1'b1; granted = 1; gcyc = c; end
        idle++;
      end
      #1;
      if (c == 0) obs_fwd_en0 = o_rd_mem_wr_en;
      if (o_dmem_req) begin
        obs_req++;
        if (obs_req == 1) begin obs_be = o_dmem_be; obs_wdata = o_dmem_wdata; end
        if (o_dmem_addr !== {addr[31:2], 2'b00} || o_dmem_be !== obs_be ||
            o_dmem_wdata !== obs_wdata) obs_unstable++;
      end
      if (o_bus_err) obs_err++;
      if (!o_stall) begin
        done = 1; obs_fwd = o_rd_mem; obs_fwd_en = o_rd_mem_wr_en;
        break;
      end
      obs_stall++;
      @(posedge i_clk); #1;
    end
    if (!done) chk({tag, "_no_completion"}, 32'd0, 32'd1);
    i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b0;
    @(posedge i_clk); #1;
    obs_err_after = o_bus_err;
    e = sb.pop_front();
    chk({tag, "_or_rd_data"},  or_rd_data,  e.data);
    chk({tag, "_or_rd_addr"},  32'(or_rd_addr), 32'(e.addr));
    chk({tag, "_or_rd_wr_en"}, 32'(or_rd_wr_en), 32'(e.wr));
    chk({tag, "_or_pc"},       or_pc,       e.pc);
  endtask

  initial begin
    i_rst = 1'b1; i_stall = 1'b0;
    i_opcode = OP_LOAD; i_funct3 = 3'b010; i_rs2_data = 32'h0; i_rd_addr = 5'd3;
    i_rd_wr_en = 1'b1; i_alu_result = 32'h40; i_pc = 32'h0;
    i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b0; i_dmem_rdata = 32'h0;

    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_req",      32'(o_dmem_req), 32'd0);
    chk("rst_stall",    32'(o_stall),    32'd0);
    chk("rst_bus_err",  32'(o_bus_err),  32'd0);
    chk("rst_rd_data",  or_rd_data,      32'd0);
    chk("rst_rd_wr_en", 32'(or_rd_wr_en), 32'd0);
    chk("rst_pc",       or_pc,           32'd0);
    i_rst = 1'b0;

    // SW with immediate grant; rd_wr_en deliberately high to show stores never write
    run_op("sw", OP_STORE, 3'b010, 32'h104, 32'hDEADBEEF, 5'd1, 1'b1, 32'h1000,
           0, -1, 32'h0, 32'h104, 1'b0);
    chk("sw_stall",  obs_stall, 1);
    chk("sw_be",     32'(obs_be), 32'hF);
    chk("sw_wdata",  obs_wdata, 32'hDEADBEEF);
    chk("sw_we",     32'(o_dmem_we), 32'd1);

    run_op("lb", OP_LOAD, 3'b000, 32'h103, 32'h0, 5'd5, 1'b1, 32'h1004,
           0, 1, 32'h80FF_0000, 32'hFFFFFF80, 1'b1);
    chk("lb_stall",    obs_stall, 2);
    chk("lb_fwd_en0",  32'(obs_fwd_en0), 32'd0);
    chk("lb_fwd",      obs_fwd, 32'hFFFFFF80);
    chk("lb_fwd_en",   32'(obs_fwd_en), 32'd1);

    run_op("lbu", OP_LOAD, 3'b100, 32'h103, 32'h0, 5'd6, 1'b1, 32'h1008,
           0, 1, 32'h80FF_0000, 32'h00000080, 1'b1);
    chk("lbu_stall", obs_stall, 2);

    run_op("sh", OP_STORE, 3'b001, 32'h102, 32'h1234ABCD, 5'd0, 1'b0, 32'h100C,
           3, -1, 32'h0, 32'h102, 1'b0);
    chk("sh_be",       32'(obs_be), 32'hC);
    chk("sh_wdata",    obs_wdata, 32'hABCDABCD);
    chk("sh_stall",    obs_stall, 4);
    chk("sh_req_cyc",  obs_req, 4);
    chk("sh_unstable", obs_unstable, 0);

    run_op("sb", OP_STORE, 3'b000, 32'h101, 32'h00000077, 5'd0, 1'b0, 32'h1010,
           0, -1, 32'h0, 32'h101, 1'b0);
    chk("sb_be",    32'(obs_be), 32'h2);
    chk("sb_wdata", obs_wdata, 32'h77777777);

    run_op("lhu", OP_LOAD, 3'b101, 32'h102, 32'h0, 5'd8, 1'b1, 32'h1014,
           0, 1, 32'h9ABC_0000, 32'h00009ABC, 1'b1);

`ifdef MEM_MISALIGN_TRAP_EN
    run_op("lw_mis", OP_LOAD, 3'b010, 32'h101, 32'h0, 5'd4, 1'b1, 32'h1018,
           0, 1, 32'h1357_9BDF, 32'h0, 1'b0);
    chk("lw_mis_req",   obs_req, 0);
    chk("lw_mis_err",   obs_err, 1);
    chk("lw_mis_stall", obs_stall, 1);
    run_op("lh_mis", OP_LOAD, 3'b001, 32'h103, 32'h0, 5'd4, 1'b1, 32'h101C,
           0, 1, 32'h8001_1234, 32'h0, 1'b0);
    chk("lh_mis_req", obs_req, 0);
    chk("lh_mis_err", obs_err, 1);
`else
    run_op("lw_mis", OP_LOAD, 3'b010, 32'h101, 32'h0, 5'd4, 1'b1, 32'h1018,
           0, 1, 32'h1357_9BDF, 32'h13579BDF, 1'b1);
    chk("lw_mis_err",   obs_err, 0);
    chk("lw_mis_stall", obs_stall, 2);
    run_op("lh_hi", OP_LOAD, 3'b001, 32'h103, 32'h0, 5'd4, 1'b1, 32'h101C,
           0, 1, 32'h8001_1234, 32'hFFFF8001, 1'b1);
    chk("lh_hi_stall", obs_stall, 2);
`endif

    run_op("add", OP_ALU, 3'b000, 32'hCAFE0001, 32'h0, 5'd7, 1'b1, 32'h1020,
           0, -1, 32'h0, 32'hCAFE0001, 1'b1);
    chk("add_stall",  obs_stall, 0);
    chk("add_fwd",    obs_fwd, 32'hCAFE0001);
    chk("add_fwd_en", 32'(obs_fwd_en), 32'd1);
    chk("add_fwd_rd", 32'(o_rd_addr_mem), 32'd7);

    // rvalid never comes: 16 WAIT cycles then a one-cycle error pulse and zero data
    run_op("tmo", OP_LOAD, 3'b010, 32'h200, 32'h0, 5'd9, 1'b1, 32'h1024,
           0, -1, 32'h0, 32'h0, 1'b1);
    chk("tmo_stall",     obs_stall, 17);
    chk("tmo_err",       obs_err, 1);
    chk("tmo_err_after", 32'(obs_err_after), 32'd0);
    chk("tmo_fwd",       obs_fwd, 32'h0);

    // Reset in the middle of a load's WAIT phase
    i_opcode = OP_LOAD; i_funct3 = 3'b010; i_alu_result = 32'h300;
    i_rd_addr = 5'd10; i_rd_wr_en = 1'b1; i_pc = 32'h1028;
    #1;
    chk("rstw_req", 32'(o_dmem_req), 32'd1);
    i_dmem_gnt = 1'b1;
    @(posedge i_clk); #1;
    i_dmem_gnt = 1'b0;
    #1;
    chk("rstw_stall_before", 32'(o_stall), 32'd1);
    i_rst = 1'b1;
    #1;
    chk("rstw_stall",    32'(o_stall), 32'd0);
    chk("rstw_req",      32'(o_dmem_req), 32'd0);
    chk("rstw_rd_data",  or_rd_data, 32'd0);
    chk("rstw_rd_addr",  32'(or_rd_addr), 32'd0);
    chk("rstw_rd_wr_en", 32'(or_rd_wr_en), 32'd0);
    chk("rstw_pc",       or_pc, 32'd0);
    sb.delete();
    #2;
    i_rst = 1'b0;

    run_op("add5", OP_ALU, 3'b000, 32'h5, 32'h0, 5'd11, 1'b1, 32'h2000,
           0, -1, 32'h0, 32'h5, 1'b1);
    chk("add5_stall", obs_stall, 0);

    // Delayed grant and delayed rvalid after reset recovery
    run_op("lw_slow", OP_LOAD, 3'b010, 32'h108, 32'h0, 5'd12, 1'b1, 32'h2004,
           1, 2, 32'h1122_3344, 32'h11223344, 1'b1);
    chk("lw_slow_stall", obs_stall, 4);
    chk("lw_slow_err",   obs_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
